// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetch and MEM load/store; MEM has priority.
// Optional bus watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_i,
  input  logic [WIDTH-1:0] if_addr_i,
  output logic             if_rvalid_o,
  output logic [WIDTH-1:0] if_rdata_o,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [3:0]       mem_be_i,
  input  logic [WIDTH-1:0] mem_addr_i,
  input  logic [WIDTH-1:0] mem_wdata_i,
  output logic             mem_rvalid_o,
  output logic [WIDTH-1:0] mem_rdata_o,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [3:0]       bus_be_o,
  output logic [WIDTH-1:0] bus_addr_o,
  output logic [WIDTH-1:0] bus_wdata_o,
  input  logic             bus_gnt_i,
  input  logic             bus_rvalid_i,
  input  logic [WIDTH-1:0] bus_rdata_i,
  output logic             stall_req_if_o,
  output logic             stall_req_mem_o,
  output logic             bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_owner_mem;
  logic             r_we;
  logic [3:0]       r_be;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic w_done_bus;
  logic w_timeout;
  logic w_done;
  logic w_start;

  // A real bus completion; suppressed while reset is asserted
  always_comb begin
    w_done_bus = 1'b0;
    unique case (r_state)
      S_REQ:   w_done_bus = bus_gnt_i & bus_rvalid_i;
      S_WAIT:  w_done_bus = bus_rvalid_i;
      default: w_done_bus = 1'b0;
    endcase
    w_done_bus = w_done_bus & ~rst;
  end

  assign w_start = (r_state == S_IDLE) & (mem_req_i | if_req_i);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

  logic [CW-1:0] r_cnt;

  // Watchdog fires only if the slave did not complete in the same cycle
  assign w_timeout = ~rst & (r_state != S_IDLE) & ~w_done_bus &
                     (r_cnt == CW'(TIMEOUT_CYCLES));

  // Cycle counter for the access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tcfg;
  assign w_unused_tcfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout     = 1'b0;
`endif

  assign w_done = w_done_bus | w_timeout;

  // Arbitration FSM and request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_mem <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'h0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mem_req_i) begin
            r_owner_mem <= 1'b1;
            r_we        <= mem_we_i;
            r_be        <= mem_be_i;
            r_addr      <= mem_addr_i;
            r_wdata     <= mem_wdata_i;
            r_state     <= S_REQ;
          end else if (if_req_i) begin
            r_owner_mem <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'hF;
            r_addr      <= if_addr_i;
            r_wdata     <= '0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end else if (bus_gnt_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req_o   = (r_state == S_REQ) & ~w_timeout & ~rst;
  assign bus_we_o    = r_we;
  assign bus_be_o    = r_be;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;

  assign if_rvalid_o  = w_done & ~r_owner_mem;
  assign mem_rvalid_o = w_done & r_owner_mem;
  assign if_rdata_o   = (if_rvalid_o & w_done_bus) ? bus_rdata_i : '0;
  assign mem_rdata_o  = (mem_rvalid_o & w_done_bus) ? bus_rdata_i : '0;
  assign bus_err_o    = w_timeout;

  assign stall_req_if_o  = if_req_i & ~if_rvalid_o;
  assign stall_req_mem_o = mem_req_i & ~mem_rvalid_o;

endmodule
